// File: rtl/alu_nibble_seq.sv
// Sequences an 8-bit Z80-style ALU operation over a 4-bit combinational slice:
// low nibble pass, high nibble pass with carry chaining, then a one-cycle done.
module alu_nibble_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       cf_in,
  output logic       ready,
  output logic       done,
  output logic [7:0] result,
  output logic       cf,
  output logic       hf,
  output logic       vf,
  output logic       zf,
  output logic       sf,
  output logic       nf,
  output logic [3:0] alu_op1,
  output logic [3:0] alu_op2,
  output logic       alu_cy_in,
  output logic       alu_R,
  output logic       alu_S,
  output logic       alu_V,
  input  logic [3:0] alu_result,
  input  logic       alu_cy_out,
  input  logic       alu_vf_out
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] lat_op;
  logic [7:0] lat_a;
  logic [7:0] lat_b;
  logic       lat_cf;
  logic [3:0] tmp;
  logic       c_mid;

  logic       is_arith;
  logic       is_sub;
  logic       lo_cin;
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [7:0] alu_word;
  logic [7:0] result_next;
  logic       cf_next;
  logic       hf_next;
  logic       vf_next;
  logic       nf_next;

  function automatic logic even_parity(input logic [7:0] v);
    return ~(^v);
  endfunction

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // Operation decode and low-pass carry selection from the latched request
  always_comb begin
    is_arith = (lat_op[2] == 1'b0) || (lat_op == OP_CP);
    is_sub   = (lat_op == OP_SUB) || (lat_op == OP_SBC) || (lat_op == OP_CP);
    case (lat_op)
      OP_ADD:       lo_cin = 1'b0;
      OP_ADC:       lo_cin = lat_cf;
      OP_SUB, OP_CP: lo_cin = 1'b1;
      OP_SBC:       lo_cin = ~lat_cf;
      default:      lo_cin = 1'b0;
    endcase
  end

  // Next-state logic and slice control drive for the two nibble passes
  always_comb begin
    state_next = state;
    alu_op1    = 4'h0;
    alu_op2    = 4'h0;
    alu_cy_in  = 1'b0;
    alu_R      = 1'b0;
    alu_S      = 1'b0;
    alu_V      = 1'b0;
    nib_a      = (state == HI) ? lat_a[7:4] : lat_a[3:0];
    nib_b      = (state == HI) ? lat_b[7:4] : lat_b[3:0];
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LO;
        end else begin
          state_next = IDLE;
        end
      end
      LO:      state_next = HI;
      HI:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if ((state == LO) || (state == HI)) begin
      alu_op1 = nib_a;
      alu_op2 = is_sub ? ~nib_b : nib_b;
      case (lat_op)
        OP_AND: begin
          alu_S     = 1'b1;
          alu_cy_in = 1'b1;
        end
        OP_XOR: begin
          alu_R = 1'b1;
        end
        OP_OR: begin
          alu_R = 1'b1;
          alu_S = 1'b1;
          alu_V = 1'b1;
        end
        default: begin
          alu_cy_in = (state == HI) ? c_mid : lo_cin;
        end
      endcase
    end else begin
      alu_op1   = 4'h0;
      alu_op2   = 4'h0;
      alu_cy_in = 1'b0;
    end
  end

  // Final result and flags, meaningful during the HI pass
  always_comb begin
    alu_word    = {alu_result, tmp};
    result_next = (lat_op == OP_CP) ? lat_a : alu_word;
    if (is_arith) begin
      // Subtract is add-of-complement, so the slice carries are inverted borrows
      cf_next = is_sub ? ~alu_cy_out : alu_cy_out;
      hf_next = is_sub ? ~c_mid : c_mid;
      vf_next = alu_vf_out;
      nf_next = is_sub;
    end else begin
      cf_next = 1'b0;
      hf_next = (lat_op == OP_AND);
      vf_next = even_parity(alu_word);
      nf_next = 1'b0;
    end
  end

  // State register, request latch, low-pass capture and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lat_op <= 3'd0;
      lat_a  <= 8'h00;
      lat_b  <= 8'h00;
      lat_cf <= 1'b0;
      tmp    <= 4'h0;
      c_mid  <= 1'b0;
      result <= 8'h00;
      cf     <= 1'b0;
      hf     <= 1'b0;
      vf     <= 1'b0;
      zf     <= 1'b0;
      sf     <= 1'b0;
      nf     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            lat_op <= op;
            lat_a  <= op_a;
            lat_b  <= op_b;
            lat_cf <= cf_in;
          end
        end
        LO: begin
          tmp   <= alu_result;
          c_mid <= alu_cy_out;
        end
        HI: begin
          result <= result_next;
          cf     <= cf_next;
          hf     <= hf_next;
          vf     <= vf_next;
          zf     <= (alu_word == 8'h00);
          sf     <= alu_word[7];
          nf     <= nf_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: behavioural 4-bit slice model,
// independent 8-bit reference model feeding a scoreboard queue.
module tb_alu_nibble_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cf_in;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic       cf, hf, vf, zf, sf, nf;
  logic [3:0] alu_op1, alu_op2;
  logic       alu_cy_in, alu_R, alu_S, alu_V;
  logic [3:0] alu_result;
  logic       alu_cy_out, alu_vf_out;
  logic [4:0] m_sum;

  int checks;
  int passed;
  logic [13:0] sb[$];

  alu_nibble_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .cf_in(cf_in), .ready(ready), .done(done), .result(result),
    .cf(cf), .hf(hf), .vf(vf), .zf(zf), .sf(sf), .nf(nf),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cy_in(alu_cy_in),
    .alu_R(alu_R), .alu_S(alu_S), .alu_V(alu_V),
    .alu_result(alu_result), .alu_cy_out(alu_cy_out), .alu_vf_out(alu_vf_out)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit slice
  always_comb begin
    m_sum      = {1'b0, alu_op1} + {1'b0, alu_op2} + {4'b0, alu_cy_in};
    alu_result = 4'h0;
    alu_cy_out = 1'b0;
    alu_vf_out = 1'b0;
    case ({alu_R, alu_S, alu_V})
      3'b000: begin
        alu_result = m_sum[3:0];
        alu_cy_out = m_sum[4];
        alu_vf_out = (alu_op1[3] == alu_op2[3]) && (m_sum[3] != alu_op1[3]);
      end
      3'b010: alu_result = alu_op1 & alu_op2;
      3'b100: alu_result = alu_op1 ^ alu_op2;
      3'b111: alu_result = alu_op1 | alu_op2;
      default: alu_result = 4'h0;
    endcase
  end

  // 8-bit reference: {result, cf, hf, vf, zf, sf, nf}
  function automatic logic [13:0] ref_op(input logic [2:0] o, input logic [7:0] a,
                                         input logic [7:0] b, input logic c);
    logic [8:0] w;
    logic [4:0] h;
    logic [7:0] v8;
    logic [7:0] r;
    logic       c1, fc, fh, fv, fn;
    w = 9'd0; h = 5'd0; v8 = 8'h00; r = 8'h00;
    c1 = 1'b0; fc = 1'b0; fh = 1'b0; fv = 1'b0; fn = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        c1 = (o == 3'd1) ? c : 1'b0;
        w  = {1'b0, a} + {1'b0, b} + {8'b0, c1};
        h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c1};
        v8 = w[7:0];
        fc = w[8];
        fh = h[4];
        fv = (a[7] == b[7]) && (v8[7] != a[7]);
        r  = v8;
      end
      3'd2, 3'd3, 3'd7: begin
        c1 = (o == 3'd3) ? c : 1'b0;
        w  = {1'b0, a} - {1'b0, b} - {8'b0, c1};
        h  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, c1};
        v8 = w[7:0];
        fc = w[8];
        fh = h[4];
        fv = (a[7] != b[7]) && (v8[7] != a[7]);
        fn = 1'b1;
        r  = (o == 3'd7) ? a : v8;
      end
      3'd4: begin v8 = a & b; fh = 1'b1; fv = ~(^v8); r = v8; end
      3'd5: begin v8 = a ^ b; fv = ~(^v8); r = v8; end
      default: begin v8 = a | b; fv = ~(^v8); r = v8; end
    endcase
    return {r, fc, fh, fv, (v8 == 8'h00), v8[7], fn};
  endfunction

  // Drives one request (optionally a junk start during LO) and waits for done.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input bit glitch, output logic [13:0] obs,
                        output logic [8:0] lo_snap, output int lat, output bit timeout);
    int guard;
    guard = 0;
    while (!ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    op = o; op_a = a; op_b = b; cf_in = c; start = 1'b1;
    sb.push_back(ref_op(o, a, b, c));
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    lo_snap = {alu_op1, alu_op2, alu_cy_in};
    if (glitch) begin
      op = 3'd6; op_a = 8'hFF; op_b = 8'hFF; cf_in = ~c; start = 1'b1;
    end
    timeout = 1'b1;
    while (lat < 10) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    obs = {result, cf, hf, vf, zf, sf, nf};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({ready, done} !== 2'b10) $display("FAIL reset_handshake: got %b expected 10", {ready, done});
    else passed++;
    checks++;
    if ({result, cf, hf, vf, zf, sf, nf} !== 14'h0) $display("FAIL reset_outputs: got %h expected 0", {result, cf, hf, vf, zf, sf, nf});
    else passed++;
    checks++;
    if ({alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V} !== 12'h0)
      $display("FAIL reset_alu: got %h expected 0", {alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V});
    else passed++;
  endtask

  task automatic test_add;
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    int lat;
    bit to;
    run_op(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b0, obs, snap, lat, to);
    exp_v = sb.pop_front();
    checks++;
    if (to || obs !== exp_v) $display("FAIL add_model: got %h expected %h", obs, exp_v);
    else passed++;
    checks++;
    if (obs !== {8'h00, 6'b110100}) $display("FAIL add_literal: got %h expected %h", obs, {8'h00, 6'b110100});
    else passed++;
    checks++;
    if (lat !== 3) $display("FAIL add_latency: got %0d expected 3", lat);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({done, ready} !== 2'b01) $display("FAIL done_pulse: got %b expected 01", {done, ready});
    else passed++;
  endtask

  task automatic test_adc;
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    int lat;
    bit to;
    run_op(3'd1, 8'h7F, 8'h00, 1'b1, 1'b0, obs, snap, lat, to);
    exp_v = sb.pop_front();
    checks++;
    if (to || obs !== exp_v) $display("FAIL adc_model: got %h expected %h", obs, exp_v);
    else passed++;
    checks++;
    if (obs[13:6] !== 8'h80 || obs[5:4] !== 2'b01 || obs[3] !== 1'b1 || obs[1] !== 1'b1)
      $display("FAIL adc_literal: got %h expected result 80 cf0 hf1 vf1 sf1", obs);
    else passed++;
    checks++;
    if (snap !== {4'hF, 4'h0, 1'b1}) $display("FAIL adc_lo_drive: got %h expected %h", snap, {4'hF, 4'h0, 1'b1});
    else passed++;
  endtask

  task automatic test_sub_sbc;
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    int lat;
    bit to;
    run_op(3'd2, 8'h10, 8'h01, 1'b0, 1'b0, obs, snap, lat, to);
    exp_v = sb.pop_front();
    checks++;
    if (to || obs !== exp_v) $display("FAIL sub_model: got %h expected %h", obs, exp_v);
    else passed++;
    checks++;
    if (obs !== {8'h0F, 6'b010001}) $display("FAIL sub_literal: got %h expected %h", obs, {8'h0F, 6'b010001});
    else passed++;
    run_op(3'd3, 8'h10, 8'h01, 1'b1, 1'b0, obs, snap, lat, to);
    exp_v = sb.pop_front();
    checks++;
    if (to || obs !== exp_v) $display("FAIL sbc_model: got %h expected %h", obs, exp_v);
    else passed++;
    checks++;
    if (obs[13:6] !== 8'h0E) $display("FAIL sbc_result: got %h expected 0e", obs[13:6]);
    else passed++;
  endtask

  task automatic test_cp;
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    int lat;
    bit to;
    run_op(3'd7, 8'h05, 8'h07, 1'b0, 1'b0, obs, snap, lat, to);
    exp_v = sb.pop_front();
    checks++;
    if (to || obs !== exp_v) $display("FAIL cp_model: got %h expected %h", obs, exp_v);
    else passed++;
    checks++;
    if (obs !== {8'h05, 6'b110011}) $display("FAIL cp_literal: got %h expected %h", obs, {8'h05, 6'b110011});
    else passed++;
  endtask

  task automatic test_logic;
    logic [2:0] ops [3] = '{3'd4, 3'd5, 3'd6};
    logic [7:0] as  [3] = '{8'hF3, 8'h0F, 8'h01};
    logic [7:0] bs  [3] = '{8'h3C, 8'hFF, 8'h02};
    logic [13:0] lit[3] = '{{8'h30, 6'b011000}, {8'hF0, 6'b001010}, {8'h03, 6'b001000}};
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b1, 1'b0, obs, snap, lat, to);
      exp_v = sb.pop_front();
      checks++;
      if (to || obs !== exp_v) $display("FAIL logic_model op%0d: got %h expected %h", ops[i], obs, exp_v);
      else passed++;
      checks++;
      if (obs !== lit[i]) $display("FAIL logic_literal op%0d: got %h expected %h", ops[i], obs, lit[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    while (!ready) begin @(posedge clk); #1; end
    op = 3'd0; op_a = 8'h11; op_b = 8'h22; cf_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({ready, done} !== 2'b10) $display("FAIL midreset_handshake: got %b expected 10", {ready, done});
    else passed++;
    checks++;
    if ({result, cf, hf, vf, zf, sf, nf, alu_op1, alu_op2, alu_cy_in} !== 23'h0)
      $display("FAIL midreset_outputs: got %h expected 0", {result, cf, hf, vf, zf, sf, nf, alu_op1, alu_op2, alu_cy_in});
    else passed++;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("FAIL midreset_no_done: got %b expected 0", saw_done);
    else passed++;
  endtask

  task automatic test_ignore_start;
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    int lat;
    bit to;
    run_op(3'd0, 8'h12, 8'h34, 1'b0, 1'b1, obs, snap, lat, to);
    exp_v = sb.pop_front();
    checks++;
    if (to || obs !== exp_v) $display("FAIL ignore_start_model: got %h expected %h", obs, exp_v);
    else passed++;
    checks++;
    if (obs[13:6] !== 8'h46) $display("FAIL ignore_start_result: got %h expected 46", obs[13:6]);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [3] = '{3'd0, 3'd5, 3'd2};
    logic [7:0] as  [3] = '{8'h81, 8'hAA, 8'h00};
    logic [7:0] bs  [3] = '{8'h7F, 8'h55, 8'h01};
    logic [13:0] obs, exp_v;
    int k, last;
    k = 0; last = 0;
    while (!ready) begin @(posedge clk); #1; end
    op = ops[0]; op_a = as[0]; op_b = bs[0]; cf_in = 1'b0; start = 1'b1;
    sb.push_back(ref_op(ops[0], as[0], bs[0], 1'b0));
    for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        obs = {result, cf, hf, vf, zf, sf, nf};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) $display("FAIL b2b_model #%0d: got %h expected %h", k, obs, exp_v);
        else passed++;
        if (k > 0) begin
          checks++;
          if (cyc - last !== 4) $display("FAIL b2b_spacing #%0d: got %0d expected 4", k, cyc - last);
          else passed++;
        end
        last = cyc;
        k++;
        if (k < 3) begin
          op = ops[k]; op_a = as[k]; op_b = bs[k];
          sb.push_back(ref_op(ops[k], as[k], bs[k], 1'b0));
        end
      end
    end
    start = 1'b0;
    checks++;
    if (k !== 3) $display("FAIL b2b_count: got %0d expected 3", k);
    else passed++;
  endtask

  task automatic test_random;
    logic [13:0] obs, exp_v;
    logic [8:0] snap;
    logic [2:0] ro;
    int lat;
    bit to;
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(7, 0));
      run_op(ro, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, obs, snap, lat, to);
      exp_v = sb.pop_front();
      checks++;
      if (to || obs !== exp_v) $display("FAIL random_model #%0d op%0d: got %h expected %h", i, ro, obs, exp_v);
      else passed++;
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; op = 3'd0;
    op_a = 8'h00; op_b = 8'h00; cf_in = 1'b0;
    checks = 0; passed = 0;
    test_reset();
    test_add();
    test_adc();
    test_sub_sbc();
    test_cp();
    test_logic();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
